// File: rtl/hls_ctrl_initiator.sv
// rtl/hls_ctrl_initiator.sv - AXI-lite master driving an HLS ap_ctrl_hs control port
// Writes argument registers, sets ap_start, polls ap_done and reports a completion status.
module hls_ctrl_initiator #(
  parameter int unsigned CTRL_ADDR_WIDTH = 6,
  parameter int unsigned NUM_ARGS        = 4,
  parameter int unsigned ARG_BASE        = 'h10,
  parameter int unsigned ARG_STRIDE      = 'h8,
  parameter int unsigned POLL_INTERVAL   = 16,
  parameter int unsigned MAX_POLLS       = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [32*NUM_ARGS-1:0]     cmd_args_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [1:0]                 status_o,
  output logic                       control_axilite_awvalid,
  input  logic                       control_axilite_awready,
  output logic [CTRL_ADDR_WIDTH-1:0] control_axilite_awaddr,
  output logic [2:0]                 control_axilite_awprot,
  output logic                       control_axilite_wvalid,
  input  logic                       control_axilite_wready,
  output logic [31:0]                control_axilite_wdata,
  output logic [3:0]                 control_axilite_wstrb,
  input  logic                       control_axilite_bvalid,
  output logic                       control_axilite_bready,
  input  logic [1:0]                 control_axilite_bresp,
  output logic                       control_axilite_arvalid,
  input  logic                       control_axilite_arready,
  output logic [CTRL_ADDR_WIDTH-1:0] control_axilite_araddr,
  output logic [2:0]                 control_axilite_arprot,
  input  logic                       control_axilite_rvalid,
  output logic                       control_axilite_rready,
  input  logic [31:0]                control_axilite_rdata,
  input  logic [1:0]                 control_axilite_rresp
);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BUS_ERR = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ARG,
    S_WR_START,
    S_WAIT,
    S_RD,
    S_FIN
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic [32*NUM_ARGS-1:0]     args_q, args_d;
  logic                       issued_q, issued_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       arvalid_q, arvalid_d;
  logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [15:0]                wait_cnt_q, wait_cnt_d;
  logic [15:0]                poll_cnt_q, poll_cnt_d;
  logic [1:0]                 status_q, status_d;

  logic                       write_phase;
  logic                       bready;
  logic                       rready;
  logic [15:0]                poll_inc;
  logic [31:0]                arg_sel;
  logic [CTRL_ADDR_WIDTH-1:0] arg_addr;
  logic                       unused_rdata;

  assign write_phase = (state_q == S_WR_ARG) || (state_q == S_WR_START);
  // B is accepted only once both address and data have been handed over.
  assign bready      = write_phase && issued_q && !awvalid_q && !wvalid_q;
  assign rready      = (state_q == S_RD) && !arvalid_q;
  assign poll_inc    = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign arg_addr    = CTRL_ADDR_WIDTH'(ARG_BASE)
                     + CTRL_ADDR_WIDTH'(idx_q) * CTRL_ADDR_WIDTH'(ARG_STRIDE);
  assign unused_rdata = ^{control_axilite_rdata[31:2], control_axilite_rdata[0]};

  always_comb begin
    arg_sel = '0;
    for (int unsigned i = 0; i < NUM_ARGS; i++) begin
      if (idx_q == 4'(i)) arg_sel = args_q[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      args_q     <= '0;
      issued_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      poll_cnt_q <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      args_q     <= args_d;
      issued_q   <= issued_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    args_d     = args_q;
    issued_d   = issued_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    poll_cnt_d = poll_cnt_q;
    status_d   = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          args_d     = cmd_args_i;
          idx_d      = '0;
          poll_cnt_d = '0;
          state_d    = S_WR_ARG;
        end
      end
      S_WR_ARG, S_WR_START: begin
        if (!issued_q) begin
          issued_d  = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = (state_q == S_WR_START) ? '0 : arg_addr;
          wdata_d   = (state_q == S_WR_START) ? 32'h1 : arg_sel;
        end else begin
          if (awvalid_q && control_axilite_awready) awvalid_d = 1'b0;
          if (wvalid_q && control_axilite_wready) wvalid_d = 1'b0;
          if (bready && control_axilite_bvalid) begin
            issued_d = 1'b0;
            if (control_axilite_bresp != 2'b00) begin
              status_d = ST_BUS_ERR;
              state_d  = S_FIN;
            end else if (state_q == S_WR_START) begin
              wait_cnt_d = 16'(POLL_INTERVAL);
              state_d    = S_WAIT;
            end else if (idx_q == 4'(NUM_ARGS - 1)) begin
              state_d = S_WR_START;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 16'd0) begin
          arvalid_d = 1'b1;
          state_d   = S_RD;
        end else begin
          wait_cnt_d = wait_cnt_q - 16'd1;
        end
      end
      S_RD: begin
        if (arvalid_q) begin
          if (control_axilite_arready) arvalid_d = 1'b0;
        end else if (control_axilite_rvalid) begin
          if (control_axilite_rresp != 2'b00) begin
            status_d = ST_BUS_ERR;
            state_d  = S_FIN;
          end else if (control_axilite_rdata[1]) begin
            status_d = ST_OK;
            state_d  = S_FIN;
          end else begin
            poll_cnt_d = poll_inc;
            if ((MAX_POLLS != 0) && (poll_inc == 16'(MAX_POLLS))) begin
              status_d = ST_TIMEOUT;
              state_d  = S_FIN;
            end else begin
              wait_cnt_d = 16'(POLL_INTERVAL);
              state_d    = S_WAIT;
            end
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o             = (state_q == S_IDLE);
  assign busy_o                  = (state_q != S_IDLE);
  assign done_o                  = (state_q == S_FIN);
  assign status_o                = (state_q == S_FIN) ? status_q : 2'd0;
  assign control_axilite_awvalid = awvalid_q;
  assign control_axilite_awaddr  = awaddr_q;
  assign control_axilite_awprot  = 3'd0;
  assign control_axilite_wvalid  = wvalid_q;
  assign control_axilite_wdata   = wdata_q;
  assign control_axilite_wstrb   = 4'hF;
  assign control_axilite_bready  = bready;
  assign control_axilite_arvalid = arvalid_q;
  assign control_axilite_araddr  = '0;
  assign control_axilite_arprot  = 3'd0;
  assign control_axilite_rready  = rready;

endmodule

// File: tb/tb_hls_ctrl_initiator.sv
// tb/tb_hls_ctrl_initiator.sv - self-checking bench for hls_ctrl_initiator
// Negedge AXI-lite slave with protocol monitor; command outcomes predicted from the register-map rules.
module tb_hls_ctrl_initiator;

  localparam int AW = 6, NARGS = 4, ABASE = 'h10, ASTRIDE = 'h8, PI = 4, MP = 3;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic cmd_valid_i = 1'b0;
  logic [32*NARGS-1:0] cmd_args_i = '0;
  logic cmd_ready_o, busy_o, done_o;
  logic [1:0] status_o;
  logic awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  logic [AW-1:0] awaddr_o, araddr_o;
  logic [2:0] awprot_o, arprot_o;
  logic [31:0] wdata_o;
  logic [3:0] wstrb_o;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  hls_ctrl_initiator #(
    .CTRL_ADDR_WIDTH(AW), .NUM_ARGS(NARGS), .ARG_BASE(ABASE), .ARG_STRIDE(ASTRIDE),
    .POLL_INTERVAL(PI), .MAX_POLLS(MP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_args_i(cmd_args_i),
    .busy_o(busy_o), .done_o(done_o), .status_o(status_o),
    .control_axilite_awvalid(awvalid_o), .control_axilite_awready(awready),
    .control_axilite_awaddr(awaddr_o), .control_axilite_awprot(awprot_o),
    .control_axilite_wvalid(wvalid_o), .control_axilite_wready(wready),
    .control_axilite_wdata(wdata_o), .control_axilite_wstrb(wstrb_o),
    .control_axilite_bvalid(bvalid), .control_axilite_bready(bready_o),
    .control_axilite_bresp(bresp),
    .control_axilite_arvalid(arvalid_o), .control_axilite_arready(arready),
    .control_axilite_araddr(araddr_o), .control_axilite_arprot(arprot_o),
    .control_axilite_rvalid(rvalid), .control_axilite_rready(rready_o),
    .control_axilite_rdata(rdata), .control_axilite_rresp(rresp)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // slave configuration (written by the stimulus block only)
  int aw_delay = 0, w_delay = 0, b_err_idx = -1, done_on = 0, r_err_on = 0;

  // slave state and logs (written by the slave block only)
  int aw_cnt = 0, w_cnt = 0, wr_seen = 0, rd_seen = 0, viol = 0;
  bit got_aw = 0, got_w = 0, got_ar = 0, b_fire = 0, r_fire = 0, prev_rst = 1;
  bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr, p_awa, p_ara;
  logic [31:0] cap_wdata, p_wd;
  logic [AW-1:0] wr_addr_log[$], rd_addr_log[$];
  logic [31:0] wr_data_log[$];
  int ar_cyc_log[$], r_cyc_log[$], b_cyc_log[$];

  always @(negedge clk) begin
    if (rst_i) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0; prev_rst = 1;
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (!prev_rst) begin
        if (p_awv && !p_awr && (!awvalid_o || awaddr_o != p_awa)) viol++;
        if (p_wv && !p_wr && (!wvalid_o || wdata_o != p_wd)) viol++;
        if (p_arv && !p_arr && (!arvalid_o || araddr_o != p_ara)) viol++;
        if (bready_o && (awvalid_o || wvalid_o)) viol++;
        if ((awvalid_o || wvalid_o || bready_o) && (arvalid_o || rready_o)) viol++;
        if (awprot_o != 3'd0 || arprot_o != 3'd0 || wstrb_o != 4'hF) viol++;
      end
      prev_rst = 0;
      if (cmd_valid_i && cmd_ready_o) begin wr_seen = 0; rd_seen = 0; end
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      if (got_aw && got_w && !bvalid) begin
        wr_addr_log.push_back(cap_awaddr);
        wr_data_log.push_back(cap_wdata);
        bresp = (wr_seen == b_err_idx) ? 2'b10 : 2'b00;
        wr_seen++;
        bvalid = 1; got_aw = 0; got_w = 0;
      end
      if (got_ar && !rvalid) begin
        rd_seen++;
        rd_addr_log.push_back(cap_araddr);
        rresp = (rd_seen == r_err_on) ? 2'b11 : 2'b00;
        rdata = ($urandom & ~32'h2) | ((rd_seen == done_on) ? 32'h2 : 32'h0);
        rvalid = 1; got_ar = 0;
      end
      awready = 0;
      if (awvalid_o && !got_aw) begin
        if (aw_cnt >= aw_delay) begin awready = 1; got_aw = 1; cap_awaddr = awaddr_o; aw_cnt = 0; end
        else aw_cnt++;
      end
      wready = 0;
      if (wvalid_o && !got_w) begin
        if (w_cnt >= w_delay) begin wready = 1; got_w = 1; cap_wdata = wdata_o; w_cnt = 0; end
        else w_cnt++;
      end
      arready = 0;
      if (arvalid_o && !got_ar) begin
        arready = 1; got_ar = 1; cap_araddr = araddr_o; ar_cyc_log.push_back(cyc);
      end
      b_fire = bvalid && bready_o;
      if (b_fire) b_cyc_log.push_back(cyc);
      r_fire = rvalid && rready_o;
      if (r_fire) r_cyc_log.push_back(cyc);
      p_awv = awvalid_o; p_awr = awready; p_awa = awaddr_o;
      p_wv = wvalid_o; p_wr = wready; p_wd = wdata_o;
      p_arv = arvalid_o; p_arr = arready; p_ara = araddr_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_cmd(input string tag, input int b_err, input int d_on, input int r_err,
                         input int awd, input int wd, input bit pulse, input bit gaps);
    logic [31:0] a [NARGS];
    int exp_nw, exp_nr, exp_st, n, wb, rb, ab, rcb, v0, k, gap;
    for (int i = 0; i < NARGS; i++) a[i] = $urandom;
    b_err_idx = b_err; done_on = d_on; r_err_on = r_err; aw_delay = awd; w_delay = wd;
    if (b_err >= 0 && b_err <= NARGS) begin
      exp_nw = b_err + 1; exp_nr = 0; exp_st = 1;
    end else begin
      exp_nw = NARGS + 1; exp_st = 2;
      for (n = 1; n <= MP; n++) begin
        if (n == r_err) begin exp_st = 1; break; end
        if (n == d_on) begin exp_st = 0; break; end
      end
      exp_nr = (n > MP) ? MP : n;
    end
    wb = wr_addr_log.size(); rb = rd_addr_log.size();
    ab = ar_cyc_log.size(); rcb = r_cyc_log.size(); v0 = viol;
    chk({tag, ":ready_idle"}, cmd_ready_o, 1);
    for (int i = 0; i < NARGS; i++) cmd_args_i[32*i +: 32] = a[i];
    cmd_valid_i = 1;
    step();
    cmd_valid_i = 0;
    chk({tag, ":busy_start"}, busy_o, 1);
    k = 0;
    while (!done_o && k < 4000) begin
      if (pulse && k == 4) begin
        cmd_valid_i = 1;
        for (int i = 0; i < NARGS; i++) cmd_args_i[32*i +: 32] = $urandom;
      end
      if (k == 6) cmd_valid_i = 0;
      step();
      k++;
    end
    cmd_valid_i = 0;
    chk({tag, ":done_seen"}, done_o, 1);
    chk({tag, ":status"}, status_o, exp_st);
    chk({tag, ":busy_at_done"}, busy_o, 1);
    step();
    chk({tag, ":done_one_cycle"}, done_o, 0);
    chk({tag, ":ready_after"}, cmd_ready_o, 1);
    chk({tag, ":busy_after"}, busy_o, 0);
    chk({tag, ":n_writes"}, wr_addr_log.size() - wb, exp_nw);
    for (int i = 0; i < exp_nw && wb + i < wr_addr_log.size(); i++) begin
      chk($sformatf("%s:waddr%0d", tag, i), wr_addr_log[wb+i],
          (i < NARGS) ? ((ABASE + i * ASTRIDE) % (1 << AW)) : 0);
      chk($sformatf("%s:wdata%0d", tag, i), wr_data_log[wb+i], (i < NARGS) ? a[i] : 32'h1);
    end
    chk({tag, ":n_reads"}, rd_addr_log.size() - rb, exp_nr);
    for (int i = rb; i < rd_addr_log.size(); i++) chk({tag, ":raddr"}, rd_addr_log[i], 0);
    if (gaps && exp_nr > 0 && ar_cyc_log.size() > ab && b_cyc_log.size() > 0) begin
      gap = ar_cyc_log[ab] - b_cyc_log[b_cyc_log.size()-1];
      chk({tag, ":first_poll_gap"}, (gap >= PI + 1 && gap <= PI + 3), 1);
      for (int j = 1; j < exp_nr && ab + j < ar_cyc_log.size(); j++) begin
        gap = ar_cyc_log[ab+j] - r_cyc_log[rcb+j-1];
        chk({tag, ":poll_gap"}, (gap >= PI + 1 && gap <= PI + 3), 1);
      end
    end
    chk({tag, ":protocol"}, viol - v0, 0);
  endtask

  initial begin
    step(3);
    chk("reset:cmd_ready", cmd_ready_o, 1);
    chk("reset:busy", busy_o, 0);
    chk("reset:done", done_o, 0);
    chk("reset:status", status_o, 0);
    chk("reset:valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 0);
    chk("reset:awaddr", awaddr_o, 0);
    chk("reset:wdata", wdata_o, 0);
    chk("reset:wstrb", wstrb_o, 4'hF);
    rst_i = 0;
    step(2);

    run_cmd("basic", -1, 3, 0, 0, 0, 0, 1);
    run_cmd("aw_slow", -1, 1, 0, 5, 0, 0, 0);
    run_cmd("w_slow", -1, 2, 0, 0, 5, 0, 0);
    run_cmd("bresp_err", 2, 1, 0, 0, 0, 0, 0);
    run_cmd("timeout", -1, 0, 0, 0, 0, 0, 1);
    run_cmd("rresp_err", -1, 3, 1, 0, 0, 1, 0);

    for (int i = 0; i < NARGS; i++) cmd_args_i[32*i +: 32] = $urandom;
    aw_delay = 1000000; w_delay = 0; b_err_idx = -1; done_on = 1; r_err_on = 0;
    cmd_valid_i = 1;
    step();
    cmd_valid_i = 0;
    step(4);
    chk("rst:aw_stalled", awvalid_o, 1);
    rst_i = 1;
    step();
    chk("rst:awvalid", awvalid_o, 0);
    chk("rst:other_valids", {wvalid_o, bready_o, arvalid_o, rready_o}, 0);
    chk("rst:cmd_ready", cmd_ready_o, 1);
    chk("rst:busy", busy_o, 0);
    rst_i = 0;
    aw_delay = 0;
    step();
    run_cmd("post_rst", -1, 2, 0, 0, 0, 0, 1);

    for (int it = 0; it < 8; it++) begin
      run_cmd($sformatf("rand%0d", it),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NARGS)) : -1,
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hls_ctrl_initiator.md
Name: hls_ctrl_initiator

Overview:
AXI-lite master that drives the `s_axi_control` slave port of an HLS kernel (Vitis `ap_ctrl_hs` register map).
- On a command, it writes NUM_ARGS 32-bit argument registers, then writes `ap_start`.
- It then polls the control register until `ap_done` is set, and returns a one-cycle completion with status.
- It sits between a local sequencer (or CSR block) and a custom HLS unit, so the unit can run without CPU software driving the control port.

Parameters:
- CTRL_ADDR_WIDTH, 6, width of control_axilite_awaddr/araddr.
- NUM_ARGS, 4, number of 32-bit argument words written per command; must be 1..15.
- ARG_BASE, 'h10, byte offset of argument 0.
- ARG_STRIDE, 'h8, byte distance between consecutive argument registers.
- POLL_INTERVAL, 16, idle cycles before each status read, 0..65535.
- MAX_POLLS, 0, status reads before timeout; 0 = unlimited.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_args_i  in  32*NUM_ARGS  argument words; word i at [32i+31:32i]
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- status_o  out  2  0=OK, 1=bus error, 2=timeout; valid when done_o
- control_axilite_awvalid/awready/awaddr[CTRL_ADDR_WIDTH]/awprot[3]  out/in/out/out  AW channel
- control_axilite_wvalid/wready/wdata[32]/wstrb[4]  out/in/out/out  W channel
- control_axilite_bvalid/bready/bresp[2]  in/out/in  B channel
- control_axilite_arvalid/arready/araddr[CTRL_ADDR_WIDTH]/arprot[3]  out/in/out/out  AR channel
- control_axilite_rvalid/rready/rdata[32]/rresp[2]  in/out/in/in  R channel

Behaviour:
Reset values and constants:
- Every output is 0 at reset.
- Exception: cmd_ready_o is 1 on the first cycle after reset.
- awprot/arprot are always 0; wstrb is always 4'hF.
- Reset mid-transaction abandons the transaction; all valids are low the cycle after the reset edge.

FSM states:
- IDLE: cmd_ready_o=1.
  - On accept, latch cmd_args_i, clear arg index and poll count, go to WR_ARG.
  - busy_o=1 from the next cycle until the cycle after done_o.
- WR_ARG: awvalid and wvalid rise together the cycle after entry.
  - awaddr = ARG_BASE + idx*ARG_STRIDE (truncated to CTRL_ADDR_WIDTH); wdata = arg[idx].
  - Each valid drops independently on its own handshake.
  - AW may complete before, after, or with W.
  - bready=1 only after both AW and W handshakes.
  - On B handshake:
    - bresp!=OKAY: go to FIN with status 1.
    - Else, if idx==NUM_ARGS-1: go to WR_START.
    - Else: idx++ and go to WR_ARG.
- WR_START: same write protocol, addr 0x00, wdata 32'h1.
  - B OKAY goes to WAIT; error goes to FIN with status 1.
- WAIT: down-counter from POLL_INTERVAL; go to RD when it reaches 0 (POLL_INTERVAL=0 → RD the next cycle).
- RD: arvalid=1, araddr=0x00, held until arready. Then rready=1 until the R handshake.
  - rresp!=OKAY: FIN with status 1.
  - rdata[1]=1 (ap_done): FIN with status 0.
  - Otherwise poll_cnt++. If MAX_POLLS!=0 and poll_cnt==MAX_POLLS, go to FIN with status 2; else go to WAIT.
- FIN: done_o=1 and status_o valid for exactly one cycle, then IDLE.

Handshake and width rules:
- No valid is deasserted before its ready; address/data stay stable while valid.
- At most one AXI-lite transaction is outstanding.
- Read and write channels are never active simultaneously.
- A cmd_valid_i seen while busy is ignored (not queued).
- poll_cnt is 16 bits, saturating.
- Latency, zero-wait slave with ready always high (cycle counts from command accept):
  - Each write takes 3 cycles (valid, B, next state).
  - Status read starts POLL_INTERVAL+1 cycles after the start-write B.

Test Plan:
- NUM_ARGS=4, args {A0,A1,A2,A3}, always-ready slave, ap_done on 3rd read → writes 0x10=A0, 0x18=A1, 0x20=A2, 0x28=A3, then 0x00=1; exactly 3 reads of 0x00; done_o with status 0; cmd_ready_o back high the next cycle.
- Slave delays awready 5 cycles while wready is immediate (and vice versa) → each valid drops on its own handshake; bready only after both; data written correctly.
- bresp=SLVERR on argument 2 → no start write, no reads; done_o with status 1.
- MAX_POLLS=3, ap_done never set → exactly 3 reads spaced POLL_INTERVAL cycles; done_o with status 2.
- rresp=DECERR on first poll → done_o with status 1; cmd_valid_i pulsed during busy is ignored.
- rst_i asserted with awvalid high and the slave stalled → awvalid=0 and cmd_ready_o=1 after reset; a new command completes normally.
